dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 13 +
 rtl/dmem_rr_arb2.sv | 42 ++++
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers and the
// registered read-response tag.
package dmem_arb_pkg;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
    } resp_tag_t;

    localparam resp_tag_t RESP_TAG_IDLE = '{valid: 1'b0, port: PORT_CORE};

    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT_CORE) ? PORT_DBG : PORT_CORE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant handshake between the two memory requesters and the
// round-robin arbiter core.
interface dmem_arbiter_if;

    logic c_req;
    logic d_req;
    logic c_gnt;
    logic d_gnt;

    modport master (output c_req, d_req, input c_gnt, d_gnt);
    modport slave  (input c_req, d_req, output c_gnt, d_gnt);

endinterface

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin grant with a registered priority pointer; the pointer
// moves to the losing port only on conflict cycles.
module dmem_rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    dmem_arbiter_if.slave  arb
);

    port_id_e ptr_q;
    port_id_e ptr_d;
    logic     conflict;

    assign conflict = arb.c_req && arb.d_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ptr_q <= PORT_CORE;
        else          ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (conflict) ptr_d = other_port(ptr_q);
    end

    // Grants are forced low during reset even though requests pass through.
    always_comb begin
        arb.c_gnt = 1'b0;
        arb.d_gnt = 1'b0;
        if (i_rst_n) begin
            if (conflict) begin
                arb.c_gnt = (ptr_q == PORT_CORE);
                arb.d_gnt = (ptr_q == PORT_DBG);
            end else begin
                arb.c_gnt = arb.c_req;
                arb.d_gnt = arb.d_req;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core MEM stage and the debug/loader
// port: combinational grant, command mux, one-cycle read-response routing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,

    input  logic                         i_c_req,
    input  logic                         i_c_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_c_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_c_wdata,
    input  logic [2:0]                   i_c_f3,
    output logic                         o_c_gnt,
    output logic                         o_c_rvalid,
    output logic [P_DATA_WIDTH-1:0]      o_c_rdata,

    input  logic                         i_d_req,
    input  logic                         i_d_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_d_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_d_wdata,
    input  logic [2:0]                   i_d_f3,
    output logic                         o_d_gnt,
    output logic                         o_d_rvalid,
    output logic [P_DATA_WIDTH-1:0]      o_d_rdata,

    output logic                         o_dmem_we,
    output logic [P_DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [P_DATA_WIDTH-1:0]      o_dmem_wdata,
    output logic [2:0]                   o_dmem_f3,
    input  logic [P_DATA_WIDTH-1:0]      i_dmem_rdata,

    output logic                         o_stall_m
);

    dmem_arbiter_if arb_bus ();

    assign arb_bus.c_req = i_c_req;
    assign arb_bus.d_req = i_d_req;
    assign o_c_gnt       = arb_bus.c_gnt;
    assign o_d_gnt       = arb_bus.d_gnt;

    dmem_rr_arb2 u_rr_arb2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .arb     (arb_bus.slave)
    );

    assign o_stall_m = i_c_req && !arb_bus.c_gnt;

    always_comb begin
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_wdata = '0;
        o_dmem_f3    = '0;
        if (arb_bus.c_gnt) begin
            o_dmem_we    = i_c_we;
            o_dmem_addr  = i_c_addr;
            o_dmem_wdata = i_c_wdata;
            o_dmem_f3    = i_c_f3;
        end else if (arb_bus.d_gnt) begin
            o_dmem_we    = i_d_we;
            o_dmem_addr  = i_d_addr;
            o_dmem_wdata = i_d_wdata;
            o_dmem_f3    = i_d_f3;
        end
    end

    resp_tag_t tag_q;
    resp_tag_t tag_d;

    always_comb begin
        tag_d = RESP_TAG_IDLE;
        if (arb_bus.c_gnt && !i_c_we)      tag_d = '{valid: 1'b1, port: PORT_CORE};
        else if (arb_bus.d_gnt && !i_d_we) tag_d = '{valid: 1'b1, port: PORT_DBG};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) tag_q <= RESP_TAG_IDLE;
        else          tag_q <= tag_d;
    end

    assign o_c_rvalid = tag_q.valid && (tag_q.port == PORT_CORE);
    assign o_d_rvalid = tag_q.valid && (tag_q.port == PORT_DBG);
    assign o_c_rdata  = o_c_rvalid ? i_dmem_rdata : '0;
    assign o_d_rdata  = o_d_rvalid ? i_dmem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a read-response scoreboard and a
// hand-written mid-read reset sequence.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 11;

    logic          clk;
    logic          rst_n;
    logic          c_we, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic [2:0]    c_f3, d_f3;
    logic          c_rvalid, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [2:0]    dmem_f3;
    logic [DW-1:0] dmem_rdata;
    logic          stall_m;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.P_DATA_WIDTH(DW), .P_DMEM_ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_c_req      (bus.c_req),
        .i_c_we       (c_we),
        .i_c_addr     (c_addr),
        .i_c_wdata    (c_wdata),
        .i_c_f3       (c_f3),
        .o_c_gnt      (bus.c_gnt),
        .o_c_rvalid   (c_rvalid),
        .o_c_rdata    (c_rdata),
        .i_d_req      (bus.d_req),
        .i_d_we       (d_we),
        .i_d_addr     (d_addr),
        .i_d_wdata    (d_wdata),
        .i_d_f3       (d_f3),
        .o_d_gnt      (bus.d_gnt),
        .o_d_rvalid   (d_rvalid),
        .o_d_rdata    (d_rdata),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .o_dmem_f3    (dmem_f3),
        .i_dmem_rdata (dmem_rdata),
        .o_stall_m    (stall_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          c_req, c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic [2:0]    c_f3;
        logic          d_req, d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [2:0]    d_f3;
        logic [DW-1:0] mem;
        logic          exp_c_gnt, exp_d_gnt;
    } vec_t;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    port_id_e    sb[$];
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input string name,
        input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd, input logic [2:0] cf,
        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd, input logic [2:0] df,
        input logic [DW-1:0] mem, input logic egc, input logic egd);
        vec_t v;
        v.name = name;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd; v.c_f3 = cf;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.d_f3 = df;
        v.mem = mem; v.exp_c_gnt = egc; v.exp_d_gnt = egd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata; c_f3 = v.c_f3;
        bus.d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_f3 = v.d_f3;
        dmem_rdata = v.mem;
    endtask

    // One cycle: drive after the edge, check mid-cycle, queue expected reads.
    task automatic apply(input vec_t v);
        logic          exp_cv, exp_dv, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic [2:0]    exp_f3;
        port_id_e      p;
        @(posedge clk); #1;
        drive(v);
        #3;
        exp_cv = 1'b0;
        exp_dv = 1'b0;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            if (p == PORT_CORE) exp_cv = 1'b1;
            else                exp_dv = 1'b1;
        end
        chk({v.name, " c_rvalid"}, {31'd0, c_rvalid}, {31'd0, exp_cv});
        chk({v.name, " d_rvalid"}, {31'd0, d_rvalid}, {31'd0, exp_dv});
        chk({v.name, " c_rdata"},  c_rdata, exp_cv ? v.mem : '0);
        chk({v.name, " d_rdata"},  d_rdata, exp_dv ? v.mem : '0);
        chk({v.name, " c_gnt"},    {31'd0, bus.c_gnt}, {31'd0, v.exp_c_gnt});
        chk({v.name, " d_gnt"},    {31'd0, bus.d_gnt}, {31'd0, v.exp_d_gnt});
        chk({v.name, " stall_m"},  {31'd0, stall_m},   {31'd0, v.c_req && !v.exp_c_gnt});
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_f3 = '0;
        if (v.exp_c_gnt) begin
            exp_we = v.c_we; exp_addr = v.c_addr; exp_wdata = v.c_wdata; exp_f3 = v.c_f3;
        end else if (v.exp_d_gnt) begin
            exp_we = v.d_we; exp_addr = v.d_addr; exp_wdata = v.d_wdata; exp_f3 = v.d_f3;
        end
        chk({v.name, " dmem_we"},    {31'd0, dmem_we},   {31'd0, exp_we});
        chk({v.name, " dmem_addr"},  {21'd0, dmem_addr}, {21'd0, exp_addr});
        chk({v.name, " dmem_wdata"}, dmem_wdata, exp_wdata);
        chk({v.name, " dmem_f3"},    {29'd0, dmem_f3},   {29'd0, exp_f3});
        if (v.exp_c_gnt && !v.c_we)      sb.push_back(PORT_CORE);
        else if (v.exp_d_gnt && !v.d_we) sb.push_back(PORT_DBG);
    endtask

    vec_t idle_v;

    initial begin
        idle_v = mk("idle", 0, 0, 11'h0, 32'h0, 3'b000, 0, 0, 11'h0, 32'h0, 3'b000, 32'h0, 0, 0);

        vecs.push_back(mk("core_rd",  1, 0, 11'h010, 32'h0,        3'b010, 0, 0, 11'h000, 32'h0,        3'b000, 32'h0,        1, 0));
        vecs.push_back(mk("core_rsp", 0, 0, 11'h000, 32'h0,        3'b000, 0, 0, 11'h000, 32'h0,        3'b000, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk("idle_ff",  0, 0, 11'h000, 32'h0,        3'b000, 0, 0, 11'h000, 32'h0,        3'b000, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk("cf1",      1, 0, 11'h100, 32'h11111111, 3'b010, 1, 0, 11'h200, 32'h22222222, 3'b001, 32'h0,        1, 0));
        vecs.push_back(mk("cf2",      1, 0, 11'h100, 32'h11111111, 3'b010, 1, 0, 11'h200, 32'h22222222, 3'b001, 32'h0000C0DE, 0, 1));
        vecs.push_back(mk("cf3",      1, 0, 11'h100, 32'h11111111, 3'b010, 1, 0, 11'h200, 32'h22222222, 3'b001, 32'h0000D00D, 1, 0));
        vecs.push_back(mk("cf4",      1, 0, 11'h100, 32'h11111111, 3'b010, 1, 0, 11'h200, 32'h22222222, 3'b001, 32'h0000BEEF, 0, 1));
        vecs.push_back(mk("dbg_wr",   0, 0, 11'h000, 32'h0,        3'b000, 1, 1, 11'h7FC, 32'h12345678, 3'b010, 32'h0BADF00D, 0, 1));
        vecs.push_back(mk("post_wr",  0, 0, 11'h000, 32'h0,        3'b000, 0, 0, 11'h000, 32'h0,        3'b000, 32'hA5A5A5A5, 0, 0));
        vecs.push_back(mk("dbg_rd",   0, 0, 11'h000, 32'h0,        3'b000, 1, 0, 11'h044, 32'h0,        3'b100, 32'h0,        0, 1));
        vecs.push_back(mk("core_rd2", 1, 0, 11'h048, 32'h0,        3'b000, 0, 0, 11'h000, 32'h0,        3'b000, 32'h55AA55AA, 1, 0));
        vecs.push_back(mk("cf_wr",    1, 1, 11'h0C0, 32'hFACEFACE, 3'b001, 1, 1, 11'h0D0, 32'h01020304, 3'b000, 32'h77777777, 1, 0));
        vecs.push_back(mk("idle2",    0, 0, 11'h000, 32'h0,        3'b000, 0, 0, 11'h000, 32'h0,        3'b000, 32'h13579BDF, 0, 0));

        // Reset state with a core request pending and memory data present.
        rst_n = 1'b0;
        drive(mk("rst", 1, 0, 11'h123, 32'h99999999, 3'b101, 1, 1, 11'h321, 32'h88888888, 3'b011, 32'hFFFFFFFF, 0, 0));
        #3;
        chk("rst c_gnt",    {31'd0, bus.c_gnt}, 32'd0);
        chk("rst d_gnt",    {31'd0, bus.d_gnt}, 32'd0);
        chk("rst dmem_we",  {31'd0, dmem_we},   32'd0);
        chk("rst dmem_addr", {21'd0, dmem_addr}, 32'd0);
        chk("rst c_rvalid", {31'd0, c_rvalid},  32'd0);
        chk("rst d_rvalid", {31'd0, d_rvalid},  32'd0);
        chk("rst c_rdata",  c_rdata, 32'd0);
        chk("rst d_rdata",  d_rdata, 32'd0);
        chk("rst stall_m",  {31'd0, stall_m},   32'd1);
        drive(idle_v);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset asserted mid-cycle after a granted core read drops the response.
        apply(mk("pre_rst_rd", 1, 0, 11'h020, 32'h0, 3'b010, 0, 0, 11'h000, 32'h0, 3'b000, 32'h0, 1, 0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst c_gnt",   {31'd0, bus.c_gnt}, 32'd0);
        chk("midrst dmem_we", {31'd0, dmem_we},   32'd0);
        chk("midrst stall_m", {31'd0, stall_m},   32'd1);
        sb.delete();
        drive(idle_v);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(mk("post_rst",   0, 0, 11'h000, 32'h0, 3'b000, 0, 0, 11'h000, 32'h0, 3'b000, 32'hCAFEF00D, 0, 0));
        apply(mk("rst_cf",     1, 0, 11'h030, 32'h0, 3'b010, 1, 0, 11'h034, 32'h0, 3'b010, 32'h0,        1, 0));
        apply(mk("rst_cf_rsp", 0, 0, 11'h000, 32'h0, 3'b000, 1, 0, 11'h034, 32'h0, 3'b010, 32'h600DD00D, 0, 1));
        apply(mk("tail",       0, 0, 11'h000, 32'h0, 3'b000, 0, 0, 11'h000, 32'h0, 3'b000, 32'h31415926, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
